// File: rtl/kyber_pkg.sv
// Shared Kyber arithmetic constants and types, used by the butterflies,
// modhalfq and the NTT controller.
package kyber_pkg;
  localparam int WIDTH     = 12;
  localparam int Q         = 3329;
  localparam int BARRETT_K = 24;
  localparam int BARRETT_M = 5039;
  localparam int P_W       = 2 * WIDTH;
  localparam int T_W       = WIDTH + 1;

  typedef logic [WIDTH-1:0] coeff_t;
endpackage

// File: rtl/barrett_reduce.sv
// Two-stage Barrett reduction of a product p < 2^24 to [0, Q-1];
// shared with the forward-NTT Cooley-Tukey butterfly.
module barrett_reduce import kyber_pkg::*; (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en_i,
  input  logic [P_W-1:0]     p_i,
  output logic [WIDTH-1:0]   r_o
);
  logic [P_W+BARRETT_M'($clog2(BARRETT_M))-1:0] prod;
  logic [T_W-1:0]   t_d, t_q;
  logic [P_W-1:0]   p_q;
  logic [T_W-1:0]   r_d;
  logic [WIDTH-1:0] v_d, v_q;

  // m = floor(2^K/Q) underestimates p/Q by less than one, so r lands in [0, 2Q)
  assign prod = (P_W+13)'(p_i) * (P_W+13)'(BARRETT_M);
  assign t_d  = T_W'(prod >> BARRETT_K);
  assign r_d  = T_W'(p_q - P_W'(t_q) * P_W'(Q));
  assign v_d  = WIDTH'((r_d >= T_W'(Q)) ? r_d - T_W'(Q) : r_d);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t_q <= '0;
      p_q <= '0;
      v_q <= '0;
    end else if (en_i) begin
      t_q <= t_d;
      p_q <= p_i;
      v_q <= v_d;
    end
  end

  assign r_o = v_q;
endmodule

// File: rtl/gs_butterfly.sv
// Four-stage Gentleman-Sande butterfly: u = a+b, v = (a-b)*zeta, both mod Q.
// A single global stall freezes every stage while the output is blocked.
module gs_butterfly import kyber_pkg::*; (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] zeta,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] u,
  output logic [WIDTH-1:0] v
);
  logic [4:1]       vld_pipe;
  logic             stall;
  logic [T_W-1:0]   sum_q, diff_q;
  logic [WIDTH-1:0] zeta_q;
  logic [WIDTH-1:0] su_d, d_d, su2_q, su3_q, u_q;
  logic [P_W-1:0]   p_d, p_q;

  assign stall     = vld_pipe[4] && !out_ready;
  assign in_ready  = !stall;
  assign out_valid = vld_pipe[4];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) vld_pipe <= '0;
    else if (!stall) vld_pipe <= {vld_pipe[3:1], in_valid};
  end

  // diff is biased by Q so it never goes negative
  assign su_d = WIDTH'((sum_q  >= T_W'(Q)) ? sum_q  - T_W'(Q) : sum_q);
  assign d_d  = WIDTH'((diff_q >= T_W'(Q)) ? diff_q - T_W'(Q) : diff_q);
  assign p_d  = P_W'(d_d) * P_W'(zeta_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sum_q  <= '0;
      diff_q <= '0;
      zeta_q <= '0;
      su2_q  <= '0;
      p_q    <= '0;
      su3_q  <= '0;
      u_q    <= '0;
    end else if (!stall) begin
      sum_q  <= {1'b0, a} + {1'b0, b};
      diff_q <= {1'b0, a} + T_W'(Q) - {1'b0, b};
      zeta_q <= zeta;
      su2_q  <= su_d;
      p_q    <= p_d;
      su3_q  <= su2_q;
      u_q    <= su3_q;
    end
  end

  barrett_reduce u_barrett (
    .clk   (clk),
    .rst_n (rst),
    .en_i  (!stall),
    .p_i   (p_q),
    .r_o   (v)
  );

  assign u = u_q;
endmodule

// File: doc/gs_butterfly.md
Name: gs_butterfly

Overview:
Pipelined Gentleman-Sande butterfly for the Kyber inverse NTT over q = 3329.
- Accepts coefficient pair (a, b) and twiddle zeta.
- Produces u = (a + b) mod q and v = ((a - b) * zeta) mod q.
- Sits directly upstream of the modular halving stage (modhalfq), which consumes u and v to apply the 1/2 scaling.
- Valid/ready handshake on both sides; fully pipelined, one butterfly per cycle when not stalled.

Parameters:
WIDTH, 12, coefficient width in bits
Q, 3329, Kyber modulus
BARRETT_K, 24, Barrett shift (2*WIDTH)
BARRETT_M, 5039, floor(2^BARRETT_K / Q)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
in_valid  in  1  input triple valid
in_ready  out  1  block can accept input this cycle
a  in  WIDTH  upper coefficient, range [0, Q-1]
b  in  WIDTH  lower coefficient, range [0, Q-1]
zeta  in  WIDTH  twiddle factor, range [0, Q-1]
out_valid  out  1  u/v valid
out_ready  in  1  downstream (modhalfq) accepts result
u  out  WIDTH  (a + b) mod Q
v  out  WIDTH  ((a - b) * zeta) mod Q

Behaviour:
- Reset (rst low, asynchronous): all stage valid bits, out_valid, u, v and all pipeline data registers go to 0; in_ready reads 1 immediately after release.
- Transfer rules:
  - Input transfers when in_valid && in_ready.
  - Output transfers when out_valid && out_ready.
- Global stall: stall = out_valid && !out_ready.
  - in_ready = !stall (combinational).
  - On stall, every stage register, including u, v and out_valid, holds.
  - No bubble collapsing.
- Latency: fixed 4 cycles from accepting edge to out_valid (no stall). Throughput 1 per cycle.
- Stage 1: register sum = a + b (WIDTH+1 bits), diff = a + Q - b (WIDTH+1 bits, range [1, 2Q-1]), zeta.
- Stage 2:
  - su = sum >= Q ? sum - Q : sum.
  - d = diff >= Q ? diff - Q : diff.
  - Register p = d * zeta (2*WIDTH bits, < Q^2 < 2^24); carry su alongside.
- Stage 3: register t = (p * BARRETT_M) >> BARRETT_K; carry p and su.
- Stage 4:
  - r = p - t*Q, range [0, 2Q).
  - v = r >= Q ? r - Q : r.
  - u = su. Both registered as outputs.
- Results are exact modular values in [0, Q-1] for every legal input. Barrett correction must cover the full 24-bit p range.
- Out-of-range inputs (>= Q): result values unspecified; handshake still obeyed, no lockup.
- Ordering: outputs leave strictly in acceptance order; no drop or duplication under arbitrary in_valid/out_ready patterns.
- Simultaneous accept and emit in the same cycle is legal and sustains full throughput.
- Reset mid-operation: all in-flight butterflies are discarded. First output after reset comes only from inputs accepted after reset release.
- u and v hold stable while out_valid && !out_ready.

Decomposition:
- Shared package kyber_pkg: WIDTH, Q, BARRETT_K, BARRETT_M, and a typedef for a coefficient (WIDTH-bit unsigned).
- Package is also used by modhalfq and the NTT controller.
- One sub-module, barrett_reduce:
  - 2 pipeline stages (stages 3 and 4), 24-bit in, WIDTH-bit out.
  - Stall enable input.
  - Reused by the forward-NTT Cooley-Tukey butterfly.

Test Plan:
- a=5, b=3, zeta=1, out_ready=1 -> 4 cycles later u=8, v=2, out_valid high for exactly one cycle.
- a=3328, b=1, zeta=1 -> u=0 (sum wrap), v=3327; then a=0, b=1, zeta=3328 -> u=1, v=1 (diff wrap, (-1)*(-1)).
- a=1000, b=2000, zeta=17 -> u=3000, v=2974; a=3328, b=0, zeta=3328 -> u=3328, v=1 (maximum product exercises Barrett correction).
- Back-to-back stream of 6 triples; drop out_ready after 2 outputs for 5 cycles:
  - in_ready goes low the same cycle.
  - u/v/out_valid are frozen.
  - All 6 results appear in order with none lost.
- Assert rst low with 3 butterflies in flight -> out_valid=0, u=v=0 asynchronously; after release, the next input's result appears at latency 4 and the stale ones never appear.
- 10,000 random legal triples with random out_ready toggling -> every (u, v) matches the golden model; u and v chained through modhalfq match (a+b)*1665 mod 3329 and (a-b)*zeta*1665 mod 3329.
